// File: rtl/tdm_frame_timing_gen.sv
// TDM frame timing generator: locks to the active-low f0 frame pulse on c4 and
// produces tx/rx bit clocks, bit enables, bit/slot position and frame_start.
module tdm_frame_timing_gen #(
  parameter int CLK_PER_BIT     = 2,
  parameter int BITS_PER_SLOT   = 8,
  parameter int SLOTS_PER_FRAME = 32,
  parameter int TOL             = 1,
  parameter int LOCK_FRAMES     = 2,
  parameter int LOSS_FRAMES     = 3,
  localparam int BIT_W          = $clog2(BITS_PER_SLOT),
  localparam int SLOT_W         = $clog2(SLOTS_PER_FRAME)
) (
  input  logic              c4,
  input  logic              rst_n,
  input  logic              f0,
  input  logic              select,
  output logic              clk_tx,
  output logic              clk_rx,
  output logic              clk_en_tx,
  output logic              clk_en_rx,
  output logic [BIT_W-1:0]  bit_idx,
  output logic [SLOT_W-1:0] slot_idx,
  output logic              frame_start,
  output logic              lock
);

  localparam int FRAME  = CLK_PER_BIT * BITS_PER_SLOT * SLOTS_PER_FRAME;
  localparam int CNT_W  = $clog2(FRAME);
  localparam int PH_W   = $clog2(CLK_PER_BIT);
  localparam int BN_W   = $clog2(BITS_PER_SLOT * SLOTS_PER_FRAME);
  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
  localparam int MISS_W = $clog2(LOSS_FRAMES + 1);
  localparam int HALF   = CLK_PER_BIT / 2;

  if (CLK_PER_BIT < 2 || (CLK_PER_BIT % 2) != 0) begin : g_bad_clk_per_bit
    $error("CLK_PER_BIT must be even and at least 2");
  end
  if (BITS_PER_SLOT < 2 || SLOTS_PER_FRAME < 2) begin : g_bad_geometry
    $error("BITS_PER_SLOT and SLOTS_PER_FRAME must be at least 2");
  end
  if (TOL < 0 || 2 * TOL + 2 > FRAME) begin : g_bad_tol
    $error("TOL must leave room for the window inside one frame");
  end
  if (LOCK_FRAMES < 1 || LOSS_FRAMES < 1) begin : g_bad_counts
    $error("LOCK_FRAMES and LOSS_FRAMES must be at least 1");
  end

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              f0_q;
  logic              seen;
  logic [GOOD_W-1:0] good;
  logic [MISS_W-1:0] miss_cnt;
  logic              f0_edge;
  logic              in_win;
  logic              chk_pt;
  logic              miss;

  assign f0_edge = f0_q & ~f0;
  assign cnt_nxt = (int'(cnt) == FRAME - 1) ? '0 : cnt + CNT_W'(1);
  assign in_win  = (int'(cnt) >= FRAME - 1 - TOL) || (int'(cnt) < TOL);
  // The window closes at cnt == TOL; a frame with no accepted edge by then is a miss.
  assign chk_pt  = (int'(cnt) == TOL);
  assign miss    = chk_pt && !seen;

  always_ff @(posedge c4 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEARCH;
      cnt      <= '0;
      f0_q     <= 1'b1;
      seen     <= 1'b0;
      good     <= '0;
      miss_cnt <= '0;
      lock     <= 1'b0;
    end else begin
      f0_q <= f0;
      lock <= (state == LOCKED);
      case (state)
        VERIFY: begin
          cnt <= cnt_nxt;
          if (f0_edge && in_win) begin
            cnt  <= '0;
            seen <= 1'b1;
            if (int'(good) + 1 >= LOCK_FRAMES) begin
              state    <= LOCKED;
              miss_cnt <= '0;
            end else begin
              good <= good + GOOD_W'(1);
            end
          end else if (f0_edge || miss) begin
            state <= SEARCH;
            cnt   <= '0;
          end else if (chk_pt) begin
            seen <= 1'b0;
          end
        end
        LOCKED: begin
          cnt <= cnt_nxt;
          if (f0_edge && in_win) begin
            cnt      <= '0;
            seen     <= 1'b1;
            miss_cnt <= '0;
          end else begin
            if (chk_pt) begin
              seen <= 1'b0;
            end
            // A stray edge and a missing one in the same cycle count as one bad frame.
            if (f0_edge || miss) begin
              if (int'(miss_cnt) + 1 >= LOSS_FRAMES) begin
                state <= SEARCH;
                cnt   <= '0;
              end else begin
                miss_cnt <= miss_cnt + MISS_W'(1);
              end
            end
          end
        end
        default: begin
          cnt      <= '0;
          seen     <= 1'b0;
          miss_cnt <= '0;
          if (f0_edge) begin
            state <= VERIFY;
            good  <= '0;
            seen  <= 1'b1;
          end
        end
      endcase
    end
  end

  // Stage p0: decode the current frame position into bit timing.
  logic              vld_p0;
  logic [PH_W-1:0]   phase_p0;
  logic [BN_W-1:0]   bit_num_p0;
  logic              tx_hi_p0;
  logic              sel_p0;
  logic              sel_q;

  assign vld_p0     = (state != SEARCH);
  assign phase_p0   = PH_W'(cnt % CNT_W'(CLK_PER_BIT));
  assign bit_num_p0 = BN_W'(cnt / CNT_W'(CLK_PER_BIT));
  assign tx_hi_p0   = (int'(phase_p0) < HALF);
  // select is only adopted on a bit boundary so clk_rx never shows a runt.
  assign sel_p0     = (phase_p0 == '0) ? select : sel_q;

  always_ff @(posedge c4 or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= 1'b0;
      clk_tx      <= 1'b0;
      clk_rx      <= 1'b0;
      clk_en_tx   <= 1'b0;
      clk_en_rx   <= 1'b0;
      bit_idx     <= '0;
      slot_idx    <= '0;
      frame_start <= 1'b0;
    end else begin
      sel_q <= sel_p0;
      if (vld_p0) begin
        clk_tx      <= tx_hi_p0;
        clk_rx      <= sel_p0 ? tx_hi_p0 : ~tx_hi_p0;
        clk_en_tx   <= (phase_p0 == '0);
        clk_en_rx   <= sel_p0 ? (phase_p0 == '0) : (int'(phase_p0) == HALF);
        bit_idx     <= BIT_W'(bit_num_p0 % BN_W'(BITS_PER_SLOT));
        slot_idx    <= SLOT_W'(bit_num_p0 / BN_W'(BITS_PER_SLOT));
        frame_start <= (cnt == '0);
      end else begin
        clk_tx      <= 1'b0;
        clk_rx      <= 1'b0;
        clk_en_tx   <= 1'b0;
        clk_en_rx   <= 1'b0;
        bit_idx     <= '0;
        slot_idx    <= '0;
        frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tdm_frame_timing_gen.sv
// Directed bench for tdm_frame_timing_gen at default parameters (512-cycle frame).
module tb_tdm_frame_timing_gen;

  logic       c4;
  logic       rst_n;
  logic       f0;
  logic       select;
  logic       clk_tx;
  logic       clk_rx;
  logic       clk_en_tx;
  logic       clk_en_rx;
  logic [2:0] bit_idx;
  logic [4:0] slot_idx;
  logic       frame_start;
  logic       lock;

  int n_checks;
  int n_fail;

  tdm_frame_timing_gen dut (
    .c4          (c4),
    .rst_n       (rst_n),
    .f0          (f0),
    .select      (select),
    .clk_tx      (clk_tx),
    .clk_rx      (clk_rx),
    .clk_en_tx   (clk_en_tx),
    .clk_en_rx   (clk_en_rx),
    .bit_idx     (bit_idx),
    .slot_idx    (slot_idx),
    .frame_start (frame_start),
    .lock        (lock)
  );

  initial c4 = 1'b0;
  always #5 c4 = ~c4;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge c4);
    #1;
  endtask

  function automatic logic [15:0] outs();
    return {2'b00, clk_tx, clk_rx, clk_en_tx, clk_en_rx, bit_idx, slot_idx, frame_start, lock};
  endfunction

  function automatic logic [15:0] pat(input int tx, input int rx, input int etx, input int erx,
                                      input int b, input int s, input int fs, input int lk);
    return {2'b00, 1'(tx), 1'(rx), 1'(etx), 1'(erx), 3'(b), 5'(s), 1'(fs), 1'(lk)};
  endfunction

  // One f0 pulse, then idle so the next call's edge lands 'period' cycles later.
  task automatic frame(input int period, input int lk, input bit detail);
    f0 = 1'b0;
    step(1);
    f0 = 1'b1;
    step(1);
    chk("frame_start_at_edge_plus2", outs(), pat(1, 0, 1, 0, 0, 0, 1, lk));
    for (int j = 1; j <= period - 2; j++) begin
      step(1);
      if (detail) begin
        case (j)
          1:   chk("pos_j1",   outs(), pat(0, 1, 0, 1, 0, 0, 0, lk));
          2:   chk("pos_j2",   outs(), pat(1, 0, 1, 0, 1, 0, 0, lk));
          15:  chk("pos_j15",  outs(), pat(0, 1, 0, 1, 7, 0, 0, lk));
          16:  chk("pos_j16",  outs(), pat(1, 0, 1, 0, 0, 1, 0, lk));
          510: chk("pos_j510", outs(), pat(1, 0, 1, 0, 7, 31, 0, lk));
          default: ;
        endcase
      end
    end
  endtask

  task automatic sel_frame();
    f0 = 1'b0;
    step(1);
    f0 = 1'b1;
    step(1);
    chk("sel0_j0", outs(), pat(1, 0, 1, 0, 0, 0, 1, 1));
    select = 1'b1;
    for (int j = 1; j <= 510; j++) begin
      step(1);
      case (j)
        1: chk("sel_hold_mid_bit", outs(), pat(0, 1, 0, 1, 0, 0, 0, 1));
        2: chk("sel1_j2",          outs(), pat(1, 1, 1, 1, 1, 0, 0, 1));
        3: chk("sel1_j3",          outs(), pat(0, 0, 0, 0, 1, 0, 0, 1));
        4: begin
          chk("sel1_j4", outs(), pat(1, 1, 1, 1, 2, 0, 0, 1));
          select = 1'b0;
        end
        5: chk("sel_hold_mid_bit2", outs(), pat(0, 0, 0, 0, 2, 0, 0, 1));
        6: chk("sel0_j6",           outs(), pat(1, 0, 1, 0, 3, 0, 0, 1));
        7: chk("sel0_j7",           outs(), pat(0, 1, 0, 1, 3, 0, 0, 1));
        default: ;
      endcase
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    f0       = 1'b1;
    select   = 1'b0;
    step(3);
    chk("reset_outputs", outs(), 16'h0000);
    rst_n = 1'b1;
    step(5);
    chk("search_idle", outs(), 16'h0000);

    // Acquisition, then +-1 period jitter while locked.
    frame(512, 0, 1'b1);
    frame(512, 0, 1'b0);
    frame(511, 1, 1'b0);
    frame(513, 1, 1'b0);
    frame(512, 1, 1'b0);
    frame(512, 1, 1'b0);

    // f0 stops: flywheel three frames, then drop lock.
    step(2);
    chk("fly_frame1", outs(), pat(1, 0, 1, 0, 0, 0, 1, 1));
    step(512);
    chk("fly_frame2", outs(), pat(1, 0, 1, 0, 0, 0, 1, 1));
    step(511);
    chk("fly_cnt511", outs(), pat(0, 1, 0, 1, 7, 31, 0, 1));
    step(1);
    chk("fly_frame3", outs(), pat(1, 0, 1, 0, 0, 0, 1, 1));
    step(1);
    chk("loss_lock_still_high", outs(), pat(0, 1, 0, 1, 0, 0, 0, 1));
    step(1);
    chk("loss_outputs_zero", outs(), 16'h0000);

    // Two edges, third late by 5: miss returns to SEARCH before it arrives.
    frame(512, 0, 1'b0);
    frame(512, 0, 1'b0);
    step(4);
    chk("late_edge_search", outs(), 16'h0000);
    step(1);
    frame(600, 0, 1'b0);
    chk("verify_miss_search", outs(), 16'h0000);

    // Two edges, third early by 5: out-of-window edge returns to SEARCH.
    frame(512, 0, 1'b0);
    frame(507, 0, 1'b0);
    f0 = 1'b0;
    step(1);
    f0 = 1'b1;
    step(1);
    chk("early_edge_search", outs(), 16'h0000);
    step(600);
    chk("search_stays_idle", outs(), 16'h0000);

    frame(512, 0, 1'b0);
    frame(512, 0, 1'b0);
    frame(512, 1, 1'b0);
    sel_frame();

    // Asynchronous reset mid-frame while locked.
    f0 = 1'b0;
    step(1);
    f0 = 1'b1;
    step(100);
    chk("pre_reset_lock", {15'd0, lock}, 16'd1);
    rst_n = 1'b0;
    #2;
    chk("async_reset_outputs", outs(), 16'h0000);
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("search_after_reset", outs(), 16'h0000);
    frame(512, 0, 1'b0);
    frame(512, 0, 1'b0);
    frame(512, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
